uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the serial path, consuming the line that the transmitter drives. Synchronises the asynchronous `rx` input, detects start bits with 16× oversampling, and samples each bit at mid-period. Delivers one received byte per frame with a one-cycle strobe plus error flags. Sits directly downstream of the TX stage, for loopback and for host-to-FPGA traffic. Frame format is 8N1, LSB first; an even-parity option is available.

## Interface

Parameters:
- `DATA_W`, 8: data bits per frame.
- `OVS`, 16: `b_tick` pulses per bit period. Must be an even number ≥ 8.

Ports. Clock is `clk`; reset is `rst`, asynchronous and active-low:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `b_tick`  in  1  oversample strobe at OVS×baud, one `clk` wide.
- `rx`  in  1  serial line, asynchronous, idle high.
- `rx_data`  out  DATA_W  last accepted byte.
- `rx_done`  out  1  one-cycle strobe: `rx_data` updated.
- `rx_busy`  out  1  high while a frame is in progress (any state other than IDLE).
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `parity_err`  out  1  one-cycle strobe: parity mismatch. Tied 0 when parity is compiled out.

## Operation

- **Synchroniser.** `rx` passes through a 2-flop synchroniser (reset value 1). A third flop holds the previous synchronised value for falling-edge detection.
- **State machine:** IDLE, START, DATA, PARITY (only if compiled in), STOP. The tick counter `tcnt` is 0..OVS-1. The bit counter `bcnt` is 0..DATA_W-1.
- **IDLE.** A synchronised falling edge moves to START with `tcnt`=0. A line held low with no edge never starts a frame.
- **START.** On the b_tick where `tcnt`=OVS/2-1:
  - line low: go to DATA, clear `tcnt` and `bcnt`;
  - line high: false start, return to IDLE with no strobe.
- **DATA.** On the b_tick where `tcnt`=OVS-1:
  - shift the sampled bit into the MSB of the shift register (shift right, so LSB arrives first);
  - `bcnt`++; after bit DATA_W-1, go to PARITY or STOP.
  - `tcnt` wraps to 0 on that same tick.
- **PARITY.** On the b_tick where `tcnt`=OVS-1, latch the mismatch: sampled bit ≠ XOR of the shift register.
- **STOP.** On the b_tick where `tcnt`=OVS-1, then always return to IDLE:
  - sampled 1: `rx_data` ← shift register, pulse `rx_done`, and pulse `parity_err` if the mismatch was latched;
  - sampled 0: pulse `frame_err`; `rx_data` is unchanged; no `rx_done` and no `parity_err`.
- **Counters.** `tcnt` advances only on `b_tick`. Between ticks, all state holds.
- **Back-to-back frames.** The FSM returns to IDLE at mid-stop-bit, so a start edge following a one-bit stop is caught.
- **Break.** After a break (line held low through STOP), the FSM waits in IDLE until the line has gone high and then falls again.

## Timing

- Reset values: `rx_data`=0, `rx_done`=0, `rx_busy`=0, `frame_err`=0, `parity_err`=0, state IDLE, counters 0.
- Reset asserted mid-frame aborts immediately; no strobe is generated.
- Input latency: 2 `clk` cycles of synchroniser latency before the line is seen internally.
- Strobe timing: `rx_done`, `frame_err` and `parity_err` are registered. They are high for exactly the one `clk` cycle after the STOP sampling tick.
- `rx_data` is valid from the cycle `rx_done` is high and holds until the next accepted frame.
- `rx_busy` rises the cycle after the edge is detected. It falls in the same cycle the strobes rise.
- Sample points: start bit at tick OVS/2 after the edge; each later bit at a further OVS ticks.

## Configuration

- Macro: `UART_RX_PARITY_EN`.
- Defined: PARITY state is present and one even-parity bit is expected between the data bits and the stop bit. `parity_err` is functional.
- Undefined: frame is 8N1, the PARITY state does not exist, and `parity_err` is constant 0.

## Test plan

Benches drive `b_tick` every 4 `clk` and `OVS`=16, so one bit = 64 `clk`.

- Frame 0x55, 8N1 → exactly one `rx_done` pulse; `rx_data`=0x55; `frame_err`=0; `rx_busy` high for the duration of the frame.
- 4-tick low glitch on an idle line → return to IDLE; no strobes; `rx_busy` low again within 5 ticks.
- Frame 0x55, then frame 0xA3 with stop bit = 0 → `frame_err` pulses once; no `rx_done`; `rx_data` remains 0x55.
- Back-to-back frames 0x00 then 0xFF, each with a single stop bit → two `rx_done` pulses; data 0x00 then 0xFF.
- Reset asserted at bit 4 of frame 0x3C → all outputs 0 during reset; after release, the next full 0x3C frame gives `rx_data`=0x3C.
- With `UART_RX_PARITY_EN`:
  - 0x07 with parity bit 1 → `rx_done`; `parity_err`=0.
  - 0x07 with parity bit 0 → `rx_done` and `parity_err` in the same cycle; `rx_data`=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with 16x oversampling, mid-bit sampling and error strobes
//
// Receives LSB-first frames of DATA_W data bits and one stop bit from an
// asynchronous serial line. Optional build macro UART_RX_PARITY_EN adds one
// even-parity bit between the data bits and the stop bit.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-low reset
//   b_tick     oversample strobe at OVS x baud, one clk wide
//   rx         serial line, asynchronous, idle high
//   rx_data    last accepted byte
//   rx_done    one-cycle strobe, rx_data updated
//   rx_busy    high while a frame is in progress
//   frame_err  one-cycle strobe, stop bit sampled low
//   parity_err one-cycle strobe, parity mismatch (constant 0 without UART_RX_PARITY_EN)

module uart_rx #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b_tick,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int TW = $clog2(OVS);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state, state_n;
  logic              rx_s1, rx_s2, rx_prev;
  logic              fall;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] data_n;
  logic              done_n, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic              par_bad, par_bad_n;
  logic              perr_q, perr_n;
`endif

  // Synchroniser resets high so a released reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall    = rx_prev & ~rx_s2;
  assign rx_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      tcnt      <= tcnt_n;
      bcnt      <= bcnt_n;
      shreg     <= shreg_n;
      rx_data   <= data_n;
      rx_done   <= done_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_n;
      perr_q    <= perr_n;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    tcnt_n    = tcnt;
    bcnt_n    = bcnt;
    shreg_n   = shreg;
    data_n    = rx_data;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_n = S_START;
          tcnt_n  = '0;
        end
      end
      S_START: begin
        if (b_tick) begin
          if (tcnt == T_HALF) begin
            tcnt_n = '0;
            if (!rx_s2) begin
              state_n = S_DATA;
              bcnt_n  = '0;
`ifdef UART_RX_PARITY_EN
              par_bad_n = 1'b0;
`endif
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state_n = S_IDLE;
            end
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (b_tick) begin
          if (tcnt == T_LAST) begin
            tcnt_n  = '0;
            shreg_n = {rx_s2, shreg[DATA_W-1:1]};
            if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end else begin
              bcnt_n = bcnt + BW'(1);
            end
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (b_tick) begin
          if (tcnt == T_LAST) begin
            tcnt_n    = '0;
            par_bad_n = rx_s2 ^ (^shreg);
            state_n   = S_STOP;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (b_tick) begin
          if (tcnt == T_LAST) begin
            // Leave at mid-stop so a start edge right after a single stop bit is seen.
            tcnt_n  = '0;
            state_n = S_IDLE;
            if (rx_s2) begin
              data_n = shreg;
              done_n = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_n = par_bad;
`endif
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       b_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err, parity_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_perr_alone = 0;
  logic [7:0] cap_data = 8'h00;
  logic [7:0] model_data = 8'h00;
  int div = 0;

  uart_rx #(.DATA_W(8), .OVS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .b_tick     (b_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      b_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rx_done) begin
        n_done++;
        cap_data = rx_data;
      end
      if (frame_err) n_ferr++;
      if (parity_err) begin
        n_perr++;
        if (!rx_done) n_perr_alone++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic v, input bit chk_busy);
    rx = v;
    repeat (32) @(negedge clk);
    if (chk_busy) check_eq("busy_mid_bit", rx_busy, 1);
    repeat (32) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    bit_time(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) bit_time(d[i], 1'b1);
`ifdef UART_RX_PARITY_EN
    bit_time(par, 1'b1);
`else
    if (par === 1'bx) rx = 1'b0;
`endif
    bit_time(stop, 1'b0);
  endtask

  // Expected outcome from frame rules: good stop delivers the byte, bad stop
  // flags a framing error, and with parity compiled in a good frame whose
  // parity bit differs from the even parity of the byte also flags parity.
  task automatic frame_and_check(input logic [7:0] d, input logic par, input logic stop);
    int  d0, f0, p0;
    bit  pbad;
    d0 = n_done;
    f0 = n_ferr;
    p0 = n_perr;
`ifdef UART_RX_PARITY_EN
    pbad = stop && (par != (^d));
`else
    pbad = 1'b0;
`endif
    send_frame(d, par, stop);
    if (stop) model_data = d;
    check_eq("done_count", n_done - d0, {31'd0, stop});
    check_eq("ferr_count", n_ferr - f0, {31'd0, !stop});
    check_eq("perr_count", n_perr - p0, {31'd0, pbad});
    check_eq("rx_data", rx_data, model_data);
    if (stop) check_eq("strobe_data", cap_data, d);
    check_eq("busy_after_stop", rx_busy, 0);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (64 * n) @(negedge clk);
  endtask

  initial begin
    int d0, f0;
    logic [7:0] dd;
    logic stop;
    logic par;

    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("reset_rx_data", rx_data, 0);
    check_eq("reset_rx_done", rx_done, 0);
    check_eq("reset_rx_busy", rx_busy, 0);
    check_eq("reset_frame_err", frame_err, 0);
    check_eq("reset_parity_err", parity_err, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    frame_and_check(8'h55, ^8'h55, 1'b1);
    idle_bits(1);

    frame_and_check(8'hA3, ^8'hA3, 1'b0);
    idle_bits(1);
    check_eq("data_kept_after_ferr", rx_data, 8'h55);

    d0 = n_done;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("glitch_busy_low", rx_busy, 0);
    repeat (40) @(negedge clk);
    check_eq("glitch_no_done", n_done - d0, 0);
    check_eq("glitch_no_ferr", n_ferr - f0, 0);

    frame_and_check(8'h00, 1'b0, 1'b1);
    frame_and_check(8'hFF, 1'b0, 1'b1);
    idle_bits(1);

    frame_and_check(8'hC6, ^8'hC6, 1'b0);
    d0 = n_done;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (192) @(negedge clk);
    check_eq("break_busy_low", rx_busy, 0);
    check_eq("break_no_done", n_done - d0, 0);
    check_eq("break_no_ferr", n_ferr - f0, 0);
    idle_bits(1);
    frame_and_check(8'h5A, ^8'h5A, 1'b1);
    idle_bits(1);

    dd = 8'h3C;
    d0 = n_done;
    f0 = n_ferr;
    bit_time(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bit_time(dd[i], 1'b0);
    rx = dd[4];
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_rx_data", rx_data, 0);
    check_eq("midrst_rx_done", rx_done, 0);
    check_eq("midrst_rx_busy", rx_busy, 0);
    check_eq("midrst_frame_err", frame_err, 0);
    check_eq("midrst_parity_err", parity_err, 0);
    model_data = 8'h00;
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (128) @(negedge clk);
    check_eq("midrst_no_done", n_done - d0, 0);
    check_eq("midrst_no_ferr", n_ferr - f0, 0);
    frame_and_check(8'h3C, ^8'h3C, 1'b1);
    idle_bits(1);

`ifdef UART_RX_PARITY_EN
    frame_and_check(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    frame_and_check(8'h07, 1'b0, 1'b1);
    idle_bits(1);
`endif

    for (int k = 0; k < 20; k++) begin
      dd   = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^dd) ^ ($urandom_range(0, 3) == 0);
      frame_and_check(dd, par, stop);
      if (!stop) idle_bits(1);
      else idle_bits($urandom_range(0, 2));
    end

    check_eq("perr_without_done", n_perr_alone, 0);
`ifndef UART_RX_PARITY_EN
    check_eq("perr_never", n_perr, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
